// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package muldiv_seq_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CALC = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_seq_alu.sv
// EX-stage ALU reused by the sequencer for its per-iteration add/subtract.
module muldiv_seq_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctr,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero
);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_ctr)
      4'b0000: result = a & b;
      4'b0001: result = a | b;
      4'b0010: begin
        result   = a + b;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0110: begin
        result   = a - b;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0111: result = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one ALU op per iteration.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hilo_rd,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import muldiv_seq_pkg::*;

  localparam int unsigned CW = $clog2(ITER);

  md_state_e        state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] acc, low, opnd;
  logic [CW-1:0]    count;
  logic             sign_q, sign_r;

  logic             is_div, is_signed;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] alu_x, alu_res, rem_sh;
  logic [3:0]       alu_ctr;
  logic             carry, borrow, fit;
  logic [WIDTH-1:0] acc_nx, low_nx, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic             alu_ovf_unused, alu_zero_unused;

  assign is_div    = (op_q == MD_DIV) || (op_q == MD_DIVU);
  assign is_signed = (op_q == MD_MULT) || (op_q == MD_DIV);
  assign stall     = busy & (hilo_rd | start | hi_we | lo_we);

  muldiv_seq_alu #(.WIDTH(WIDTH)) u_alu (
    .a        (alu_x),
    .b        (opnd),
    .alu_ctr  (alu_ctr),
    .result   (alu_res),
    .overflow (alu_ovf_unused),
    .zero     (alu_zero_unused)
  );

  // One iteration step plus sign-corrected final result for the last step.
  always_comb begin
    mag_a    = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    mag_b    = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
    rem_sh   = {acc[WIDTH-2:0], low[WIDTH-1]};
    alu_x    = acc;
    alu_ctr  = ALU_ADD;
    carry    = 1'b0;
    borrow   = 1'b0;
    fit      = 1'b0;
    acc_nx   = acc;
    low_nx   = low;
    if (is_div) begin
      alu_x   = rem_sh;
      alu_ctr = ALU_SUB;
      borrow  = (~rem_sh[WIDTH-1] & opnd[WIDTH-1]) |
                ((~rem_sh[WIDTH-1] | opnd[WIDTH-1]) & alu_res[WIDTH-1]);
      // bit shifted out of the remainder is the 33rd bit of the trial value
      fit     = acc[WIDTH-1] | ~borrow;
      acc_nx  = fit ? alu_res : rem_sh;
      low_nx  = {low[WIDTH-2:0], fit};
    end else begin
      carry = (acc[WIDTH-1] & opnd[WIDTH-1]) |
              ((acc[WIDTH-1] | opnd[WIDTH-1]) & ~alu_res[WIDTH-1]);
      if (low[0]) {acc_nx, low_nx} = {carry, alu_res, low[WIDTH-1:1]};
      else        {acc_nx, low_nx} = {1'b0, acc, low[WIDTH-1:1]};
    end
    prod     = {acc_nx, low_nx};
    prod_fix = sign_q ? -prod : prod;
    if (!is_div) begin
      {res_hi, res_lo} = prod_fix;
    end else if (b_q == '0) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
      res_hi = sign_r ? -acc_nx : acc_nx;
      res_lo = sign_q ? -low_nx : low_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      low    <= '0;
      opnd   <= '0;
      count  <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            busy  <= 1'b1;
            state <= ST_PREP;
          end
        end
        ST_PREP: begin
          sign_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          sign_r <= is_signed & a_q[WIDTH-1];
          acc    <= '0;
          count  <= '0;
          low    <= is_div ? mag_a : mag_b;
          opnd   <= is_div ? mag_b : mag_a;
          state  <= ST_CALC;
        end
        ST_CALC: begin
          acc   <= acc_nx;
          low   <= low_nx;
          count <= count + CW'(1);
          // HI/LO land on entry to FIX so they are visible with done
          if (count == CW'(ITER - 1)) begin
            hi    <= res_hi;
            lo    <= res_lo;
            done  <= 1'b1;
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
